// File: rtl/sdii_pkg.sv
// sdii_pkg: shared state encoding, default widths and the most-negative-value helper
package sdii_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  localparam int N_DEF = 64;
  localparam int W_DEF = 8;
  localparam int MAX_N = 256;
  function automatic logic [MAX_N-1:0] MIN_NEG(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction
endpackage

// File: rtl/sign_magnitude_negative_chunk.sv
// negative_chunk: one W-bit slice of a two's-complement negation with ripple carry
module negative_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout
);
  assign y    = ~x + {{(W-1){1'b0}}, cin};
  assign cout = cin & (x == '0);
endmodule

// File: rtl/sign_magnitude.sv
// sign_magnitude: two's-complement to sign-magnitude, negating negatives one W-bit chunk per cycle
module sign_magnitude
  import sdii_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] number,
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [N-1:0] magnitude,
  output logic         min_neg
);
  localparam int C = N / W;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0] MIN_NEG_V = N'(MIN_NEG(N));
  state_t state_q, state_d;
  logic [N-1:0] work_q, work_d, mag_q, mag_d, rot;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, pend_q, pend_d, busy_q, busy_d, done_q, done_d;
  logic sign_q, sign_d, min_neg_q, min_neg_d, cout;
  logic [W-1:0] out;
  negative_chunk #(.W(W)) u_chunk (
    .x    (work_q[W-1:0]),
    .cin  (carry_q),
    .y    (out),
    .cout (cout)
  );
  assign rot = (N > W) ? {out, work_q[N-1:W]} : out;
  // Next-state: accept in IDLE, rotate one negated chunk per CONV cycle, publish on the last
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sign_d    = sign_q;
    mag_d     = mag_q;
    min_neg_d = min_neg_q;
    if (state_q == IDLE) begin
      if (start && !number[N-1]) begin
        mag_d     = number;
        sign_d    = 1'b0;
        min_neg_d = 1'b0;
        done_d    = 1'b1;
      end else if (start) begin
        work_d  = number;
        carry_d = 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b1;
        pend_d  = (number == MIN_NEG_V);
        state_d = CONV;
      end
    end else begin
      work_d  = rot;
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(C - 1)) begin
        mag_d     = rot;
        sign_d    = 1'b1;
        min_neg_d = pend_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    end
  end
  // State and output registers; reset aborts any conversion without a done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      min_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      min_neg_q <= min_neg_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign sign      = sign_q;
  assign magnitude = mag_q;
  assign min_neg   = min_neg_q;
endmodule

// File: tb/tb_sign_magnitude.sv
// tb_sign_magnitude: directed checks of sign_magnitude with default N=64, W=8
module tb_sign_magnitude;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] number = '0;
  logic busy, done, sign, min_neg;
  logic [63:0] magnitude;
  int tests = 0;
  int fails = 0;

  sign_magnitude dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .number    (number),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .magnitude (magnitude),
    .min_neg   (min_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " sign"}, 64'(sign), 64'd0);
    chk({tag, " mag"}, magnitude, 64'd0);
    chk({tag, " min_neg"}, 64'(min_neg), 64'd0);
  endtask

  // Negative conversion: accept, 7 more busy cycles, done on the 8th CONV edge.
  // With poke set, a start with number=7 is raised mid-conversion and must be ignored.
  task automatic neg_conv(input string tag, input logic [63:0] num, input logic [63:0] emag,
                          input logic emin, input logic poke);
    start = 1'b1;
    number = num;
    step;
    start = 1'b0;
    chk({tag, " busy@accept"}, 64'(busy), 64'd1);
    for (int k = 1; k < 8; k++) begin
      if (poke && k == 3) begin
        start = 1'b1;
        number = 64'd7;
      end
      step;
      chk({tag, " busy&!done"}, {62'd0, busy, done}, 64'd2);
    end
    step;
    start = 1'b0;
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy_off"}, 64'(busy), 64'd0);
    chk({tag, " sign"}, 64'(sign), 64'd1);
    chk({tag, " mag"}, magnitude, emag);
    chk({tag, " min_neg"}, 64'(min_neg), 64'(emin));
  endtask

  initial begin
    #1;
    chk_zero("reset");
    step;
    step;
    reset_n = 1'b1;
    step;
    chk_zero("idle");

    start = 1'b1;
    number = 64'd5;
    step;
    start = 1'b0;
    chk("pos done", 64'(done), 64'd1);
    chk("pos sign", 64'(sign), 64'd0);
    chk("pos mag", magnitude, 64'd5);
    chk("pos busy", 64'(busy), 64'd0);
    step;
    chk("pos done_once", 64'(done), 64'd0);
    chk("pos hold", magnitude, 64'd5);

    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    step;
    chk_zero("reset_hold");
    reset_n = 1'b1;
    step;

    neg_conv("m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    step;
    chk("m1 done_once", 64'(done), 64'd0);

    neg_conv("m256", 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 1'b0, 1'b1);
    step;
    chk("m256 ignored done", 64'(done), 64'd0);
    chk("m256 ignored mag", magnitude, 64'h100);
    chk("m256 ignored busy", 64'(busy), 64'd0);

    neg_conv("minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    start = 1'b1;
    number = 64'd0;
    step;
    start = 1'b0;
    chk("b2b done", 64'(done), 64'd1);
    chk("b2b sign", 64'(sign), 64'd0);
    chk("b2b mag", magnitude, 64'd0);
    chk("b2b min_neg", 64'(min_neg), 64'd0);

    start = 1'b1;
    number = 64'hFFFF_FFFF_FFFF_FFFD;
    step;
    start = 1'b0;
    step;
    step;
    step;
    reset_n = 1'b0;
    #1 chk_zero("midconv_reset");
    step;
    chk_zero("midconv_hold");
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step;
      chk("abort no_done", 64'(done), 64'd0);
    end
    neg_conv("m3", 64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
